// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one external 32-bit add/subtract unit between two requesters.
// Operands are held on the adder for ADD_LAT cycles, then Sum/Cout/overflow are returned on a valid/ready channel.
module addsub_arbiter #(
    parameter int unsigned ADD_LAT = 1  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,
    input  logic        req0_sub,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,
    input  logic        req1_sub,
    output logic        req1_ready,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    output logic        add_sub,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_ovf,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ADD_LAT);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        op_cin_q, op_cin_d;
    logic        op_sub_q, op_sub_d;
    logic        id_q, id_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;

    logic        grant0, grant1;
    logic        accept;
    logic        exec_done;
    logic        ovf_calc;

    // On a tie the requester that did not win last time is served.
    assign grant0    = req0_valid & (~req1_valid | last_grant_q);
    assign grant1    = req1_valid & (~req0_valid | ~last_grant_q);
    assign accept    = (state_q == IDLE) & (req0_valid | req1_valid);
    assign exec_done = (state_q == EXEC) & (cnt_q == 4'd1);

    assign ovf_calc = op_sub_q ? ((op_a_q[31] != op_b_q[31]) & (add_sum[31] != op_a_q[31]))
                               : ((op_a_q[31] == op_b_q[31]) & (add_sum[31] != op_a_q[31]));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:    if (exec_done) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        rsp_valid  = (state_q == RESP);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_cin_d     = op_cin_q;
        op_sub_d     = op_sub_q;
        id_d         = id_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        if (accept) begin
            op_a_d       = grant1 ? req1_a   : req0_a;
            op_b_d       = grant1 ? req1_b   : req0_b;
            op_cin_d     = grant1 ? req1_cin : req0_cin;
            op_sub_d     = grant1 ? req1_sub : req0_sub;
            id_d         = grant1;
            last_grant_d = grant1;
            cnt_d        = CNT_INIT;
        end
        if (state_q == EXEC) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (exec_done) begin
            sum_d  = add_sum;
            cout_d = add_cout;
            ovf_d  = ovf_calc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            op_cin_q     <= 1'b0;
            op_sub_q     <= 1'b0;
            id_q         <= 1'b0;
            sum_q        <= 32'd0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cin_q     <= op_cin_d;
            op_sub_q     <= op_sub_d;
            id_q         <= id_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
        end
    end

    // The adder sees the operand registers directly, so its inputs only move on an accept.
    assign add_a    = op_a_q;
    assign add_b    = op_b_q;
    assign add_cin  = op_cin_q;
    assign add_sub  = op_sub_q;
    assign rsp_id   = id_q;
    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;
    assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: one instance with ADD_LAT=1 and one with ADD_LAT=3,
// each closed around its own behavioural adder.
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_cin = 1'b0, req0_sub = 1'b0, req1_cin = 1'b0, req1_sub = 1'b0;
    logic        rsp_ready = 1'b1;

    logic        u1_req0_ready, u1_req1_ready, u1_add_cin, u1_add_sub, u1_add_cout;
    logic [31:0] u1_add_a, u1_add_b, u1_add_sum, u1_rsp_sum;
    logic        u1_rsp_valid, u1_rsp_id, u1_rsp_cout, u1_rsp_ovf;

    logic        u3_req0_ready, u3_req1_ready, u3_add_cin, u3_add_sub, u3_add_cout;
    logic [31:0] u3_add_a, u3_add_b, u3_add_sum, u3_rsp_sum;
    logic        u3_rsp_valid, u3_rsp_id, u3_rsp_cout, u3_rsp_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Adder: add is a+b+cin, subtract is a-b-cin (carry out = no borrow).
    assign {u1_add_cout, u1_add_sum} = u1_add_sub ?
        ({1'b0, u1_add_a} + {1'b0, ~u1_add_b} + {32'd0, ~u1_add_cin}) :
        ({1'b0, u1_add_a} + {1'b0, u1_add_b} + {32'd0, u1_add_cin});
    assign {u3_add_cout, u3_add_sum} = u3_add_sub ?
        ({1'b0, u3_add_a} + {1'b0, ~u3_add_b} + {32'd0, ~u3_add_cin}) :
        ({1'b0, u3_add_a} + {1'b0, u3_add_b} + {32'd0, u3_add_cin});

    addsub_arbiter #(.ADD_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req0_sub(req0_sub), .req0_ready(u1_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .req1_sub(req1_sub), .req1_ready(u1_req1_ready),
        .add_a(u1_add_a), .add_b(u1_add_b), .add_cin(u1_add_cin), .add_sub(u1_add_sub),
        .add_sum(u1_add_sum), .add_cout(u1_add_cout),
        .rsp_valid(u1_rsp_valid), .rsp_id(u1_rsp_id), .rsp_sum(u1_rsp_sum),
        .rsp_cout(u1_rsp_cout), .rsp_ovf(u1_rsp_ovf), .rsp_ready(rsp_ready)
    );

    addsub_arbiter #(.ADD_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req0_sub(req0_sub), .req0_ready(u3_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .req1_sub(req1_sub), .req1_ready(u3_req1_ready),
        .add_a(u3_add_a), .add_b(u3_add_b), .add_cin(u3_add_cin), .add_sub(u3_add_sub),
        .add_sum(u3_add_sum), .add_cout(u3_add_cout),
        .rsp_valid(u3_rsp_valid), .rsp_id(u3_rsp_id), .rsp_sum(u3_rsp_sum),
        .rsp_cout(u3_rsp_cout), .rsp_ovf(u3_rsp_ovf), .rsp_ready(rsp_ready)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    // One operation through the ADD_LAT=1 instance with rsp_ready held high.
    task automatic op1(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [31:0] e_sum,
                       input logic e_ovf, input logic do_cout, input logic e_cout);
        @(negedge clk);
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1;
        end
        #1;
        chk1("op_ready_own",   id ? u1_req1_ready : u1_req0_ready, 1'b1);
        chk1("op_ready_other", id ? u1_req0_ready : u1_req1_ready, 1'b0);
        @(posedge clk); #1;
        chk1("op_exec_ready", id ? u1_req1_ready : u1_req0_ready, 1'b0);
        chk1("op_exec_rspv",  u1_rsp_valid, 1'b0);
        chk32("op_exec_add_a", u1_add_a, a);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        chk1("op_rspv",   u1_rsp_valid, 1'b1);
        chk1("op_rsp_id", u1_rsp_id, id);
        chk32("op_sum",   u1_rsp_sum, e_sum);
        chk1("op_ovf",    u1_rsp_ovf, e_ovf);
        if (do_cout) chk1("op_cout", u1_rsp_cout, e_cout);
        @(posedge clk); #1;
        chk1("op_rspv_clr", u1_rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int last_acc;
        int nacc;

        // Reset state
        #1;
        chk1("rst_rspv",   u1_rsp_valid, 1'b0);
        chk32("rst_add_a", u1_add_a, 32'd0);
        chk1("rst_ready0", u1_req0_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single operations, ADD_LAT=1
        op1(1'b0, 32'd2, 32'd6, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0);
        op1(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        op1(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        op1(1'b1, 32'd65535, 32'd65153, 1'b0, 1'b1, 32'd382, 1'b0, 1'b0, 1'b0);
        op1(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Round-robin with both requesters continuously valid; last grant was 1
        req0_a = 32'd10; req0_b = 32'd1; req0_cin = 1'b0; req0_sub = 1'b0;
        req1_a = 32'd20; req1_b = 32'd2; req1_cin = 1'b0; req1_sub = 1'b0;
        cyc = 0; last_acc = -1; nacc = 0;
        for (int t = 0; t < 20 && nacc < 4; t++) begin
            @(negedge clk);
            if (t == 0) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
            end
            #1;
            cyc++;
            if (u1_rsp_valid) begin
                chk1("rr_rsp_id", u1_rsp_id, 1'((nacc - 1) % 2));
                chk32("rr_rsp_sum", u1_rsp_sum, ((nacc - 1) % 2 == 1) ? 32'd22 : 32'd11);
            end
            if (u1_req0_ready || u1_req1_ready) begin
                chk1("rr_onehot", u1_req0_ready & u1_req1_ready, 1'b0);
                chk1("rr_grant", u1_req1_ready, 1'(nacc % 2));
                if (last_acc >= 0) chk32("rr_interval", cyc - last_acc, 32'd3);
                last_acc = cyc;
                nacc++;
            end
        end
        chk32("rr_count", nacc, 32'd4);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);

        // ADD_LAT=3 instance: held operands, stalled response
        @(negedge clk);
        rst = 1'b1; rsp_ready = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        req0_a = 32'd100; req0_b = 32'd23; req0_cin = 1'b0; req0_sub = 1'b0; req0_valid = 1'b1;
        #1;
        chk1("l3_ready0", u3_req0_ready, 1'b1);
        @(posedge clk); #1;
        chk32("l3_e0_add_a", u3_add_a, 32'd100);
        chk32("l3_e0_add_b", u3_add_b, 32'd23);
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 32'd999; req0_b = 32'd999;
        req1_a = 32'd7; req1_b = 32'd8; req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk32("l3_exec_add_a", u3_add_a, 32'd100);
            chk32("l3_exec_add_b", u3_add_b, 32'd23);
            chk1("l3_exec_rspv", u3_rsp_valid, 1'b0);
            chk1("l3_exec_ready1", u3_req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        chk1("l3_rspv_rise", u3_rsp_valid, 1'b1);
        chk32("l3_sum", u3_rsp_sum, 32'd123);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk1("l3_hold_rspv", u3_rsp_valid, 1'b1);
            chk32("l3_hold_sum", u3_rsp_sum, 32'd123);
            chk1("l3_hold_id", u3_rsp_id, 1'b0);
            chk1("l3_hold_ovf", u3_rsp_ovf, 1'b0);
            chk1("l3_hold_ready1", u3_req1_ready, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk1("l3_hs_ready1", u3_req1_ready, 1'b0);
        @(posedge clk); #1;
        chk1("l3_after_rspv", u3_rsp_valid, 1'b0);
        chk1("l3_after_ready1", u3_req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;

        // Reset during EXEC aborts the operation and restores the tie-break
        @(negedge clk);
        req0_a = 32'd5; req0_b = 32'd6; req0_valid = 1'b1;
        #1;
        chk1("ab_ready0", u3_req0_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk32("ab_add_a", u3_add_a, 32'd0);
        chk32("ab_add_b", u3_add_b, 32'd0);
        chk1("ab_rspv", u3_rsp_valid, 1'b0);
        chk32("ab_rsp_sum", u3_rsp_sum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk1("ab_no_rspv", u3_rsp_valid, 1'b0);
        end
        @(negedge clk);
        req0_a = 32'd1; req0_b = 32'd1; req1_a = 32'd2; req1_b = 32'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk1("ab_tie_ready0", u3_req0_ready, 1'b1);
        chk1("ab_tie_ready1", u3_req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
